missed_evt_monitor_param: RTL and testbench

- Counts per-channel TDC hits that are dropped while the output FIFO is almost full.
- After the FIFO drains, it flushes one summary word per non-zero channel into the output FIFO.
- Parametrised successor for N-channel data stream controllers. Adds configurable channel count, counter width and threshold, a valid qualifier, saturation, a write acknowledge, forced flush and abort on FIFO refill.
- Sits beside the channel mux in the data stream controller. Its write request has highest priority at the output FIFO arbiter.

---
 rtl/missed_evt_monitor_param_if.sv | 31 +++
 rtl/missed_evt_monitor_param.sv | 148 ++++++++++++++
 tb/tb_missed_evt_monitor_param.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/missed_evt_monitor_param_if.sv
// rtl/missed_evt_monitor_param_if.sv - write handshake between missed-event monitor and output FIFO arbiter
//
// Purpose: carries the summary word, its write request and the arbiter's
//          write acknowledge.
// Signals:
//   missedEvtData      summary word {ch, count, sat, 1'b0}
//   missedEvtWriteReq  monitor requests a write of missedEvtData
//   missedEvtWriteAck  arbiter accepted missedEvtData this cycle
// Modports:
//   master  monitor side (drives data/req, receives ack)
//   slave   arbiter side (receives data/req, drives ack)

interface missed_evt_monitor_param_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] missedEvtData;
  logic              missedEvtWriteReq;
  logic              missedEvtWriteAck;

  modport master (
    output missedEvtData,
    output missedEvtWriteReq,
    input  missedEvtWriteAck
  );

  modport slave (
    input  missedEvtData,
    input  missedEvtWriteReq,
    output missedEvtWriteAck
  );
endinterface

// File: rtl/missed_evt_monitor_param.sv
// rtl/missed_evt_monitor_param.sv - per-channel missed TDC hit counter with flush to output FIFO
//
// Purpose: counts channel words dropped while the output FIFO is almost full
//          and, once the FIFO drains (or on a forced flush), writes one
//          summary word per non-zero channel, lowest channel first.
// Ports:
//   clk                     stream clock
//   reset                   synchronous, active-high reset
//   dataType                type of current word; 0..NCH-1 are channel data
//   dataValid               dataType qualifies a real word this cycle
//   output_fifo_almostfull  output FIFO almost-full flag
//   flushForce              single-cycle pulse, flush all non-zero counts
//   evt_if (master)         missedEvtData / missedEvtWriteReq / missedEvtWriteAck
//   missedEvtSat            sticky per-channel saturation flags

module missed_evt_monitor_param #(
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 28,
  parameter int TYPE_W = 3,
  parameter int THRESH = 100
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TYPE_W-1:0]          dataType,
  input  logic                       dataValid,
  input  logic                       output_fifo_almostfull,
  input  logic                       flushForce,
  missed_evt_monitor_param_if.master evt_if,
  output logic [NCH-1:0]             missedEvtSat
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             af_d;
  logic [CNT_W-1:0] cnt [NCH];

  logic [NCH-1:0]   inc;      // channel sees a dropped word this edge
  logic [NCH-1:0]   nz;       // channel count non-zero
  logic [NCH-1:0]   gt;       // channel count above THRESH
  logic [NCH-1:0]   sel_oh;   // one-hot of the selected channel
  logic [NCH-1:0]   clr;      // selected channel accepted by the arbiter
  logic [CH_W-1:0]  sel;
  logic [CNT_W-1:0] sel_cnt;
  logic             other_nz; // something besides the selected channel pending
  logic             ack_flush;

  // Per-channel status. The threshold compare is done at 64 bits so that a
  // THRESH larger than a narrow counter's range is never truncated.
  always_comb begin
    inc = '0;
    nz  = '0;
    gt  = '0;
    for (int i = 0; i < NCH; i++) begin
      inc[i] = output_fifo_almostfull && dataValid && (dataType == TYPE_W'(i));
      nz[i]  = (cnt[i] != '0);
      gt[i]  = (64'(cnt[i]) > 64'(THRESH));
    end
  end

  // Lowest non-zero channel wins; walking downwards lets the lowest index
  // overwrite any higher one.
  always_comb begin
    sel     = '0;
    sel_cnt = cnt[0];
    sel_oh  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (nz[i]) begin
        sel       = CH_W'(i);
        sel_cnt   = cnt[i];
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign other_nz  = |(nz & ~sel_oh);
  assign ack_flush = (state == FLUSH) && evt_if.missedEvtWriteAck;
  assign clr       = ack_flush ? sel_oh : '0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((af_d && !output_fifo_almostfull && (|gt)) || (flushForce && (|nz))) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (evt_if.missedEvtWriteAck) begin
          if (!(other_nz && !output_fifo_almostfull)) begin
            state_nxt = IDLE;
          end
        end else if (output_fifo_almostfull) begin
          // FIFO refilled before the word was taken: give the arbiter back
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: the request is the FLUSH state; the word always shows the
  // current selection so it is stable while the request waits for an ack.
  always_comb begin
    evt_if.missedEvtWriteReq = (state == FLUSH);
    evt_if.missedEvtData     = {sel, sel_cnt, (sel_cnt == CNT_MAX), 1'b0};
  end

  // Almost-full delay and per-channel counters
  always_ff @(posedge clk) begin
    if (reset) begin
      af_d         <= 1'b0;
      missedEvtSat <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      af_d <= output_fifo_almostfull;
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          // A miss in the same cycle as the ack starts the next count at 1
          cnt[i] <= inc[i] ? CNT_W'(1) : '0;
        end else if (inc[i]) begin
          if (cnt[i] == CNT_MAX) begin
            missedEvtSat[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_missed_evt_monitor_param.sv
// tb/tb_missed_evt_monitor_param.sv - self-checking bench for missed_evt_monitor_param

module tb_missed_evt_monitor_param;

  localparam int NCH    = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 28;
  localparam int TYPE_W = 3;
  localparam int THRESH = 100;
  localparam int DW     = CH_W + CNT_W + 2;
  localparam longint MAXC = (64'd1 << CNT_W) - 1;

  localparam int CNT_W2  = 4;
  localparam int THRESH2 = 10;
  localparam int DW2     = CH_W + CNT_W2 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [TYPE_W-1:0] dataType = '0;
  logic              dataValid = 1'b0;
  logic              af = 1'b0;
  logic              flushForce = 1'b0;
  logic [NCH-1:0]    sat;

  logic [TYPE_W-1:0] s_type = '0;
  logic              s_valid = 1'b0;
  logic              s_af = 1'b0;
  logic              s_force = 1'b0;
  logic [NCH-1:0]    sat2;

  missed_evt_monitor_param_if #(.DATA_W(DW))  evt_if ();
  missed_evt_monitor_param_if #(.DATA_W(DW2)) evt2_if ();

  missed_evt_monitor_param #(
    .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .TYPE_W(TYPE_W), .THRESH(THRESH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .dataType               (dataType),
    .dataValid              (dataValid),
    .output_fifo_almostfull (af),
    .flushForce             (flushForce),
    .evt_if                 (evt_if),
    .missedEvtSat           (sat)
  );

  missed_evt_monitor_param #(
    .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W2), .TYPE_W(TYPE_W), .THRESH(THRESH2)
  ) dut2 (
    .clk                    (clk),
    .reset                  (reset),
    .dataType               (s_type),
    .dataValid              (s_valid),
    .output_fifo_almostfull (s_af),
    .flushForce             (s_force),
    .evt_if                 (evt2_if),
    .missedEvtSat           (sat2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: counts per channel plus "is flushing" and the delayed
  // almost-full, updated from the rules once per clock edge.
  longint         mcnt [NCH];
  bit             mreq;
  bit             maf_d;
  bit [NCH-1:0]   msat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_nz();
    int s = 0;
    for (int i = NCH - 1; i >= 0; i--) if (mcnt[i] != 0) s = i;
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    int s = lowest_nz();
    return {CH_W'(s), CNT_W'(mcnt[s]), (mcnt[s] == MAXC), 1'b0};
  endfunction

  task automatic model_edge();
    int s;
    bit anynz, anygt, other, nreq, ack;
    bit [NCH-1:0] inc;
    if (reset) begin
      for (int i = 0; i < NCH; i++) mcnt[i] = 0;
      mreq = 0; maf_d = 0; msat = '0;
      return;
    end
    ack = evt_if.missedEvtWriteAck;
    s = lowest_nz();
    anynz = 0; anygt = 0; other = 0;
    for (int i = 0; i < NCH; i++) begin
      inc[i] = af && dataValid && (int'(dataType) == i);
      if (mcnt[i] != 0) anynz = 1;
      if (mcnt[i] > THRESH) anygt = 1;
      if (i != s && mcnt[i] != 0) other = 1;
    end
    if (!mreq)    nreq = (maf_d && !af && anygt) || (flushForce && anynz);
    else if (ack) nreq = other && !af;
    else          nreq = !af;
    for (int i = 0; i < NCH; i++) begin
      if (mreq && ack && i == s) mcnt[i] = inc[i] ? 1 : 0;
      else if (inc[i]) begin
        if (mcnt[i] == MAXC) msat[i] = 1;
        else mcnt[i]++;
      end
    end
    maf_d = af;
    mreq  = nreq;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("req",  64'(evt_if.missedEvtWriteReq), 64'(mreq));
    chk("data", 64'(evt_if.missedEvtData), 64'(exp_data()));
    chk("sat",  64'(sat), 64'(msat));
  endtask

  task automatic drive(input int t, input bit v, input bit a, input bit f, input bit k);
    dataType   = TYPE_W'(t);
    dataValid  = v;
    af         = a;
    flushForce = f;
    evt_if.missedEvtWriteAck = k;
  endtask

  task automatic misses(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      drive(ch, 1, 1, 0, 0);
      tick();
    end
  endtask

  initial begin
    evt_if.missedEvtWriteAck  = 1'b0;
    evt2_if.missedEvtWriteAck = 1'b0;
    for (int i = 0; i < NCH; i++) mcnt[i] = 0;
    mreq = 0; maf_d = 0; msat = '0;

    // Reset state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_req",  64'(evt_if.missedEvtWriteReq), 64'd0);
    chk("reset_data", 64'(evt_if.missedEvtData), 64'd0);
    chk("reset_sat",  64'(sat), 64'd0);

    // 150 misses on ch2, drain, single ack
    misses(2, 150);
    drive(0, 0, 0, 0, 0); tick();
    chk("ch2_req",  64'(evt_if.missedEvtWriteReq), 64'd1);
    chk("ch2_data", 64'(evt_if.missedEvtData), 64'({2'd2, 28'd150, 1'b0, 1'b0}));
    drive(0, 0, 0, 0, 1); tick();
    chk("ch2_done", 64'(evt_if.missedEvtWriteReq), 64'd0);

    // Two channels flushed in order
    misses(0, 50);
    misses(3, 120);
    drive(0, 0, 0, 0, 0); tick();
    chk("two_first", 64'(evt_if.missedEvtData), 64'({2'd0, 28'd50, 1'b0, 1'b0}));
    drive(0, 0, 0, 0, 1); tick();
    chk("two_second", 64'(evt_if.missedEvtData), 64'({2'd3, 28'd120, 1'b0, 1'b0}));
    chk("two_req",    64'(evt_if.missedEvtWriteReq), 64'd1);
    tick();
    chk("two_done",   64'(evt_if.missedEvtWriteReq), 64'd0);

    // Below threshold: no automatic flush, then forced flush
    misses(1, 80);
    drive(0, 0, 0, 0, 0); tick(); tick(); tick();
    chk("below_thr", 64'(evt_if.missedEvtWriteReq), 64'd0);
    drive(0, 0, 0, 1, 0); tick();
    chk("force_req",  64'(evt_if.missedEvtWriteReq), 64'd1);
    chk("force_data", 64'(evt_if.missedEvtData), 64'({2'd1, 28'd80, 1'b0, 1'b0}));
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0); tick();

    // Abort on refill, then restart from ch0
    misses(0, 120);
    misses(2, 30);
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    chk("abort_req",  64'(evt_if.missedEvtWriteReq), 64'd0);
    chk("abort_data", 64'(evt_if.missedEvtData), 64'({2'd0, 28'd120, 1'b0, 1'b0}));
    drive(0, 0, 0, 0, 0); tick();
    chk("restart_req", 64'(evt_if.missedEvtWriteReq), 64'd1);
    drive(0, 0, 0, 0, 1); tick(); tick();
    chk("restart_end", 64'(evt_if.missedEvtWriteReq), 64'd0);
    drive(0, 0, 0, 0, 0); tick();

    // Ack concurrent with a ch0 miss, then reset mid-flush
    misses(0, 110);
    misses(1, 5);
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 0, 1); tick();
    chk("ackinc_req",  64'(evt_if.missedEvtWriteReq), 64'd0);
    chk("ackinc_data", 64'(evt_if.missedEvtData), 64'({2'd0, 28'd1, 1'b0, 1'b0}));
    drive(0, 0, 0, 1, 0); tick();
    chk("preflush_req", 64'(evt_if.missedEvtWriteReq), 64'd1);
    drive(0, 0, 0, 0, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_req",  64'(evt_if.missedEvtWriteReq), 64'd0);
    chk("midrst_data", 64'(evt_if.missedEvtData), 64'd0);

    // Randomized traffic against the model
    begin
      bit a = 0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 99) == 0) a = ~a;
        drive($urandom_range(0, 5), $urandom_range(0, 3) != 0, a,
              $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
        reset = ($urandom_range(0, 999) == 0);
        tick();
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);
    end

    // Saturation on the narrow-counter build
    reset = 1'b1; tick(); reset = 1'b0;
    s_type = '0; s_valid = 1'b1; s_af = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_flag", 64'(sat2[0]), 64'd1);
    chk("sat_data", 64'(evt2_if.missedEvtData), 64'({2'd0, 4'd15, 1'b1, 1'b0}));
    s_valid = 1'b0; s_af = 1'b0; tick();
    chk("sat_req", 64'(evt2_if.missedEvtWriteReq), 64'd1);
    evt2_if.missedEvtWriteAck = 1'b1; tick();
    evt2_if.missedEvtWriteAck = 1'b0;
    chk("sat_done",   64'(evt2_if.missedEvtWriteReq), 64'd0);
    chk("sat_sticky", 64'(sat2), 64'd1);
    chk("sat_clear",  64'(evt2_if.missedEvtData), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
